// File: rtl/y86_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module  : y86_regfile_sb
// Purpose : Y86 register file with two bypassed read ports, two write ports
//           and a per-register pending-write scoreboard that stalls issue.
// Revision: 1.0 - initial release
// ============================================================================
module y86_regfile_sb #(
    parameter int DATA_W = 64,
    parameter int NREG   = 15,
    parameter int AW     = 4,
    parameter int CNT_W  = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              issue_valid_i,
    input  logic [AW-1:0]     srcA_i,
    input  logic [AW-1:0]     srcB_i,
    input  logic [AW-1:0]     dstE_i,
    input  logic [AW-1:0]     dstM_i,
    output logic              issue_ready_o,
    output logic [DATA_W-1:0] valA_o,
    output logic [DATA_W-1:0] valB_o,
    input  logic              wbE_en_i,
    input  logic [AW-1:0]     wbE_dst_i,
    input  logic [DATA_W-1:0] wbE_data_i,
    input  logic              wbM_en_i,
    input  logic [AW-1:0]     wbM_dst_i,
    input  logic [DATA_W-1:0] wbM_data_i,
    output logic [NREG-1:0]   busy_o,
    output logic              err_o
);

    localparam logic [AW-1:0]    RNONE   = '1;
    localparam int               SW      = CNT_W + 2;
    localparam logic [SW-1:0]    CNT_MAX = SW'((1 << CNT_W) - 1);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [CNT_W-1:0]  cnt_q  [NREG];
    logic [CNT_W-1:0]  cnt_d  [NREG];
    logic              err_q;
    logic              err_d;

    logic [SW-1:0]     ret_w    [NREG];
    logic [SW-1:0]     claims_w [NREG];
    logic              stall_w;
    logic              accept_w;

    function automatic logic idx_ok(input logic [AW-1:0] idx);
        return (idx != RNONE) && (32'(idx) < NREG);
    endfunction

    // M has priority over E on the bypass, matching the write priority.
    always_comb begin
        valA_o = '0;
        if (idx_ok(srcA_i)) begin
            if (wbM_en_i && wbM_dst_i == srcA_i)      valA_o = wbM_data_i;
            else if (wbE_en_i && wbE_dst_i == srcA_i) valA_o = wbE_data_i;
            else                                      valA_o = regs_q[srcA_i];
        end
    end

    always_comb begin
        valB_o = '0;
        if (idx_ok(srcB_i)) begin
            if (wbM_en_i && wbM_dst_i == srcB_i)      valB_o = wbM_data_i;
            else if (wbE_en_i && wbE_dst_i == srcB_i) valB_o = wbE_data_i;
            else                                      valB_o = regs_q[srcB_i];
        end
    end

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            ret_w[r]    = SW'(wbE_en_i && wbE_dst_i == AW'(r))
                        + SW'(wbM_en_i && wbM_dst_i == AW'(r));
            claims_w[r] = SW'(dstE_i == AW'(r)) + SW'(dstM_i == AW'(r));
        end
    end

    // Sources wait on writes not retiring this cycle; claims must fit the counter.
    always_comb begin
        stall_w = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            if ((srcA_i == AW'(r) || srcB_i == AW'(r)) && SW'(cnt_q[r]) > ret_w[r])
                stall_w = 1'b1;
            if (SW'(cnt_q[r]) + claims_w[r] > CNT_MAX + ret_w[r])
                stall_w = 1'b1;
        end
    end

    assign issue_ready_o = ~stall_w;
    assign accept_w      = issue_valid_i & issue_ready_o;

    always_comb begin
        logic [SW-1:0] sum;
        sum   = '0;
        err_d = err_q;
        for (int r = 0; r < NREG; r++) begin
            sum = SW'(cnt_q[r]) + (accept_w ? claims_w[r] : '0);
            if (sum < ret_w[r]) begin
                cnt_d[r] = '0;
                err_d    = 1'b1;
            end else begin
                cnt_d[r] = CNT_W'(sum - ret_w[r]);
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NREG; r++) regs_d[r] = regs_q[r];
        if (wbE_en_i && idx_ok(wbE_dst_i)) regs_d[wbE_dst_i] = wbE_data_i;
        if (wbM_en_i && idx_ok(wbM_dst_i)) regs_d[wbM_dst_i] = wbM_data_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= DATA_W'(r);
                cnt_q[r]  <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= regs_d[r];
                cnt_q[r]  <= cnt_d[r];
            end
            err_q <= err_d;
        end
    end

    always_comb begin
        for (int r = 0; r < NREG; r++) busy_o[r] = (cnt_q[r] != '0);
    end

    assign err_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_y86_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module  : tb_y86_regfile_sb
// Purpose : Directed self-checking bench for y86_regfile_sb.
// Revision: 1.0 - initial release
// ============================================================================
module tb_y86_regfile_sb;

    localparam int DATA_W = 64;
    localparam int NREG   = 15;
    localparam int AW     = 4;
    localparam int CNT_W  = 2;
    localparam logic [AW-1:0] RN = 4'hF;

    logic              clk = 1'b0;
    logic              rst;
    logic              issue_valid;
    logic [AW-1:0]     src_a, src_b, dst_e, dst_m;
    logic              issue_ready;
    logic [DATA_W-1:0] val_a, val_b;
    logic              wbe_en, wbm_en;
    logic [AW-1:0]     wbe_dst, wbm_dst;
    logic [DATA_W-1:0] wbe_data, wbm_data;
    logic [NREG-1:0]   busy;
    logic              err;

    int passed = 0;
    int total  = 0;

    y86_regfile_sb #(.DATA_W(DATA_W), .NREG(NREG), .AW(AW), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst), .issue_valid_i(issue_valid),
        .srcA_i(src_a), .srcB_i(src_b), .dstE_i(dst_e), .dstM_i(dst_m),
        .issue_ready_o(issue_ready), .valA_o(val_a), .valB_o(val_b),
        .wbE_en_i(wbe_en), .wbE_dst_i(wbe_dst), .wbE_data_i(wbe_data),
        .wbM_en_i(wbm_en), .wbM_dst_i(wbm_dst), .wbM_data_i(wbm_data),
        .busy_o(busy), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic idle();
        issue_valid = 0; src_a = RN; src_b = RN; dst_e = RN; dst_m = RN;
        wbe_en = 0; wbe_dst = RN; wbe_data = '0;
        wbm_en = 0; wbm_dst = RN; wbm_data = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        #2;
        total++; if (busy !== '0 || err !== 1'b0) $display("FAIL reset_state busy=%h err=%b want 0/0", busy, err); else passed++;
        @(negedge clk);
        rst = 0;
        src_a = 4'd3; src_b = RN;
        #1;
        total++; if (val_a !== 64'd3) $display("FAIL reset_valA got %h want 3", val_a); else passed++;
        total++; if (val_b !== 64'd0) $display("FAIL reset_valB_rnone got %h want 0", val_b); else passed++;
        total++; if (issue_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", issue_ready); else passed++;
    endtask

    task automatic test_bypass();
        idle();
        issue_valid = 1; dst_e = 4'd2;
        step();
        idle();
        src_a = 4'd2;
        #1;
        total++; if (issue_ready !== 1'b0) $display("FAIL raw_stall got %b want 0", issue_ready); else passed++;
        total++; if (busy[2] !== 1'b1) $display("FAIL busy2_set got %b want 1", busy[2]); else passed++;
        wbe_en = 1; wbe_dst = 4'd2; wbe_data = 64'hAB;
        #1;
        total++; if (val_a !== 64'hAB) $display("FAIL bypass_e got %h want ab", val_a); else passed++;
        total++; if (issue_ready !== 1'b1) $display("FAIL bypass_ready got %b want 1", issue_ready); else passed++;
        step();
        wbe_en = 0;
        #1;
        total++; if (busy[2] !== 1'b0) $display("FAIL busy2_clear got %b want 0", busy[2]); else passed++;
        total++; if (val_a !== 64'hAB) $display("FAIL reg2_written got %h want ab", val_a); else passed++;
        total++; if (err !== 1'b0) $display("FAIL no_err_bypass got %b want 0", err); else passed++;
    endtask

    task automatic test_both_ports();
        idle();
        issue_valid = 1; dst_e = 4'd4; dst_m = 4'd4;
        step();
        idle();
        src_a = 4'd4;
        wbe_en = 1; wbe_dst = 4'd4; wbe_data = 64'h10;
        wbm_en = 1; wbm_dst = 4'd4; wbm_data = 64'h20;
        #1;
        total++; if (val_a !== 64'h20) $display("FAIL m_wins_bypass got %h want 20", val_a); else passed++;
        total++; if (issue_ready !== 1'b1) $display("FAIL dual_retire_ready got %b want 1", issue_ready); else passed++;
        step();
        wbe_en = 0; wbm_en = 0;
        #1;
        total++; if (val_a !== 64'h20) $display("FAIL m_wins_write got %h want 20", val_a); else passed++;
        total++; if (busy[4] !== 1'b0) $display("FAIL dual_retire_busy got %b want 0", busy[4]); else passed++;
    endtask

    task automatic test_dual_claim();
        idle();
        issue_valid = 1; dst_e = 4'd4; dst_m = 4'd4;
        step();
        idle();
        src_a = 4'd4;
        wbe_en = 1; wbe_dst = 4'd4; wbe_data = 64'h31;
        #1;
        total++; if (issue_ready !== 1'b0) $display("FAIL partial_retire_stall got %b want 0", issue_ready); else passed++;
        step();
        wbe_en = 0;
        #1;
        total++; if (busy[4] !== 1'b1) $display("FAIL busy4_after_e got %b want 1", busy[4]); else passed++;
        wbm_en = 1; wbm_dst = 4'd4; wbm_data = 64'h32;
        step();
        wbm_en = 0;
        #1;
        total++; if (busy[4] !== 1'b0) $display("FAIL busy4_after_m got %b want 0", busy[4]); else passed++;
        total++; if (val_a !== 64'h32) $display("FAIL reg4_m got %h want 32", val_a); else passed++;
    endtask

    task automatic test_overflow();
        idle();
        issue_valid = 1; dst_e = 4'd5;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (issue_ready !== 1'b1) $display("FAIL fill_ready%0d got %b want 1", i, issue_ready); else passed++;
            step();
        end
        total++; if (issue_ready !== 1'b0) $display("FAIL ovf_stall got %b want 0", issue_ready); else passed++;
        step();
        total++; if (busy[5] !== 1'b1) $display("FAIL ovf_hold_busy got %b want 1", busy[5]); else passed++;
        wbe_en = 1; wbe_dst = 4'd5; wbe_data = 64'h55;
        #1;
        total++; if (issue_ready !== 1'b1) $display("FAIL ovf_retire_ready got %b want 1", issue_ready); else passed++;
        step();
        issue_valid = 0; dst_e = RN;
        for (int i = 0; i < 3; i++) begin
            total++; if (busy[5] !== 1'b1) $display("FAIL drain_busy%0d got %b want 1", i, busy[5]); else passed++;
            step();
        end
        wbe_en = 0;
        #1;
        total++; if (busy[5] !== 1'b0) $display("FAIL drain_done got %b want 0", busy[5]); else passed++;
        total++; if (err !== 1'b0) $display("FAIL drain_no_err got %b want 0", err); else passed++;
    endtask

    task automatic test_rnone_write();
        idle();
        wbe_en = 1; wbe_dst = RN; wbe_data = 64'hDEAD;
        src_a = RN;
        #1;
        total++; if (val_a !== 64'd0) $display("FAIL rnone_read got %h want 0", val_a); else passed++;
        step();
        wbe_en = 0;
        #1;
        total++; if (err !== 1'b0) $display("FAIL rnone_no_err got %b want 0", err); else passed++;
    endtask

    task automatic test_underflow_and_reset();
        idle();
        wbe_en = 1; wbe_dst = 4'd6; wbe_data = 64'h66;
        step();
        idle();
        src_a = 4'd6;
        #1;
        total++; if (err !== 1'b1) $display("FAIL underflow_err got %b want 1", err); else passed++;
        total++; if (val_a !== 64'h66) $display("FAIL underflow_write got %h want 66", val_a); else passed++;
        total++; if (busy[6] !== 1'b0) $display("FAIL underflow_cnt got %b want 0", busy[6]); else passed++;
        issue_valid = 1; dst_e = 4'd7;
        step();
        idle();
        src_a = 4'd6;
        total++; if (err !== 1'b1 || busy[7] !== 1'b1) $display("FAIL sticky err=%b busy7=%b want 1/1", err, busy[7]); else passed++;
        #2;
        rst = 1;
        #1;
        total++; if (err !== 1'b0 || busy !== '0) $display("FAIL async_reset err=%b busy=%h want 0/0", err, busy); else passed++;
        total++; if (val_a !== 64'd6) $display("FAIL async_reset_reg got %h want 6", val_a); else passed++;
        @(negedge clk);
        rst = 0;
        wbe_en = 1; wbe_dst = 4'd7; wbe_data = 64'h77;
        step();
        wbe_en = 0;
        #1;
        total++; if (err !== 1'b1) $display("FAIL post_reset_underflow got %b want 1", err); else passed++;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_bypass();
        test_both_ports();
        test_dual_claim();
        test_overflow();
        test_rnone_write();
        test_underflow_and_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
